// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
//
// Round-robin front end that shares one 8x8 sequential multiplier among NREQ
// requesters. One transaction at a time: pick a pending requester, launch the
// multiplier with a one-cycle start pulse, wait for done (bounded by TIMEOUT),
// then return the 16-bit product with a one-hot ack and the requester index.
//
// Parameters
//   NREQ     number of requesters (2..8)
//   IDW      requester index width, ceil(log2(NREQ))
//   TIMEOUT  cycles allowed from start until the transaction is aborted (>= 2)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   req         per-requester request level
//   a_in, b_in  packed operands, slice i = x_in[8*i+7:8*i]
//   ack         one-hot, one-cycle completion pulse to the served requester
//   err         1 = transaction timed out (result forced to 0), valid with ack
//   result      16-bit unsigned product, held until the next completion
//   result_id   index of the served requester, held until the next completion
//   busy        high whenever a transaction is in flight
//   mult_a/b    operands to the multiplier, stable from launch until done
//   mult_start  one-cycle start pulse to the multiplier
//   mult_r      multiplier result
//   mult_done   multiplier done level
// -----------------------------------------------------------------------------
module mult_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [8*NREQ-1:0]    a_in,
    input  logic [8*NREQ-1:0]    b_in,
    output logic [NREQ-1:0]      ack,
    output logic                 err,
    output logic [15:0]          result,
    output logic [IDW-1:0]       result_id,
    output logic                 busy,
    output logic [7:0]           mult_a,
    output logic [7:0]           mult_b,
    output logic                 mult_start,
    input  logic [15:0]          mult_r,
    input  logic                 mult_done
);

    localparam int CNTW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_GUARD = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]       state_q,      state_d;
    logic [IDW-1:0]   rr_ptr_q,     rr_ptr_d;
    logic [IDW-1:0]   grant_id_q,   grant_id_d;
    logic [CNTW-1:0]  cnt_q,        cnt_d;
    logic [7:0]       mult_a_q,     mult_a_d;
    logic [7:0]       mult_b_q,     mult_b_d;
    logic             mult_start_q, mult_start_d;
    logic [NREQ-1:0]  ack_q,        ack_d;
    logic             err_q,        err_d;
    logic [15:0]      result_q,     result_d;
    logic [IDW-1:0]   result_id_q,  result_id_d;

    logic             found;
    logic [IDW-1:0]   sel_id;
    logic [CNTW-1:0]  cnt_inc;
    logic [NREQ-1:0]  grant_onehot;

    // Round-robin pick: first set req bit strictly after rr_ptr, wrapping
    // modulo NREQ, so the most recently served requester is considered last.
    always_comb begin
        found  = 1'b0;
        sel_id = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int             idx;
            logic [IDW-1:0] cand;
            idx  = (int'(rr_ptr_q) + k) % NREQ;
            cand = IDW'(idx);
            if (!found && req[cand]) begin
                found  = 1'b1;
                sel_id = cand;
            end
        end
    end

    assign cnt_inc      = cnt_q + 1'b1;
    assign grant_onehot = {{(NREQ-1){1'b0}}, 1'b1} << grant_id_q;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        cnt_d        = cnt_q;
        mult_a_d     = mult_a_q;
        mult_b_d     = mult_b_q;
        mult_start_d = 1'b0;
        ack_d        = '0;
        err_d        = err_q;
        result_d     = result_q;
        result_id_d  = result_id_q;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    mult_a_d     = a_in[8*int'(sel_id) +: 8];
                    mult_b_d     = b_in[8*int'(sel_id) +: 8];
                    grant_id_d   = sel_id;
                    // Registered so the pulse lines up with the ISSUE state.
                    mult_start_d = 1'b1;
                    state_d      = S_ISSUE;
                end
            end

            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_GUARD;
            end

            // mult_done may still be asserted from the previous operation;
            // this cycle lets the multiplier drop it before it is trusted.
            S_GUARD: begin
                state_d = S_WAIT;
            end

            // Completion outputs are registered on the way into RESP so they
            // are valid exactly in the ack cycle. Done has priority over the
            // timeout when both happen together. The timeout compares the
            // incremented count, which places the aborted ack TIMEOUT cycles
            // after GUARD.
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (mult_done) begin
                    result_d    = mult_r;
                    err_d       = 1'b0;
                    result_id_d = grant_id_q;
                    ack_d       = grant_onehot;
                    state_d     = S_RESP;
                end else if (cnt_inc == CNTW'(TIMEOUT - 1)) begin
                    result_d    = 16'h0000;
                    err_d       = 1'b1;
                    result_id_d = grant_id_q;
                    ack_d       = grant_onehot;
                    state_d     = S_RESP;
                end
            end

            S_RESP: begin
                rr_ptr_d = grant_id_q;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A reset mid-transaction simply drops it: no ack is produced and any
    // later multiplier result is ignored because the FSM restarts in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= IDW'(NREQ - 1);
            grant_id_q   <= '0;
            cnt_q        <= '0;
            mult_a_q     <= 8'h00;
            mult_b_q     <= 8'h00;
            mult_start_q <= 1'b0;
            ack_q        <= '0;
            err_q        <= 1'b0;
            result_q     <= 16'h0000;
            result_id_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id_q   <= grant_id_d;
            cnt_q        <= cnt_d;
            mult_a_q     <= mult_a_d;
            mult_b_q     <= mult_b_d;
            mult_start_q <= mult_start_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            result_q     <= result_d;
            result_id_q  <= result_id_d;
        end
    end

    assign ack        = ack_q;
    assign err        = err_q;
    assign result     = result_q;
    assign result_id  = result_id_q;
    assign busy       = (state_q != S_IDLE);
    assign mult_a     = mult_a_q;
    assign mult_b     = mult_b_q;
    assign mult_start = mult_start_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_arbiter
//
// Self-checking bench for mult_arbiter. Expected operands and responses are
// queued when stimulus is issued; a monitor pops them whenever the DUT pulses
// mult_start or ack. A behavioural multiplier model answers the DUT with
// configurable latency, a stale-done mode and a never-done mode.
// -----------------------------------------------------------------------------
module tb_mult_arbiter;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 64;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [8*NREQ-1:0]   a_in;
    logic [8*NREQ-1:0]   b_in;
    logic [NREQ-1:0]     ack;
    logic                err;
    logic [15:0]         result;
    logic [IDW-1:0]      result_id;
    logic                busy;
    logic [7:0]          mult_a;
    logic [7:0]          mult_b;
    logic                mult_start;
    logic [15:0]         mult_r    = 16'h0000;
    logic                mult_done = 1'b0;

    logic [7:0] opa [NREQ];
    logic [7:0] opb [NREQ];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign a_in[8*g +: 8] = opa[g];
        assign b_in[8*g +: 8] = opb[g];
    end

    mult_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
        .ack(ack), .err(err), .result(result), .result_id(result_id),
        .busy(busy), .mult_a(mult_a), .mult_b(mult_b),
        .mult_start(mult_start), .mult_r(mult_r), .mult_done(mult_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // ---------------- multiplier model ----------------
    int         lat     = 2;   // edges after start until done/result
    int         stale_n = 0;   // 0: done drops at start; 1: stale done kept through GUARD
    bit         hang    = 1'b0;
    int         mt      = 0;
    logic [7:0] ma      = 8'h00;
    logic [7:0] mb      = 8'h00;

    always @(posedge clk) begin
        if (mult_start === 1'b1) begin
            mt <= 1;
            ma <= mult_a;
            mb <= mult_b;
            if (stale_n == 0) mult_done <= 1'b0;
        end else if (mt > 0) begin
            mt <= mt + 1;
            if (mt == stale_n) mult_done <= 1'b0;
            if (!hang && mt == lat) begin
                mult_done <= 1'b1;
                mult_r    <= 16'(ma) * 16'(mb);
                mt        <= 0;
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct { int id; int res; int e; } rsp_t;
    typedef struct { int a;  int b; }          op_t;

    rsp_t exp_q[$];
    op_t  op_q[$];
    int   last_served = NREQ - 1;

    task automatic push_txn(input int id, input int a, input int b, input int e);
        op_t  o;
        rsp_t r;
        o.a = a; o.b = b;
        r.id = id; r.res = (e != 0) ? 0 : a * b; r.e = e;
        op_q.push_back(o);
        exp_q.push_back(r);
        last_served = id;
    endtask

    // All requesters in mask hold their request until served: service order
    // is repeated "next pending index after the last one served".
    task automatic predict(input logic [NREQ-1:0] mask);
        logic [NREQ-1:0] pend;
        pend = mask;
        while (pend != '0) begin
            int nxt;
            nxt = -1;
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (last_served + k) % NREQ;
                if (nxt < 0 && pend[c]) nxt = c;
            end
            pend[nxt] = 1'b0;
            push_txn(nxt, int'(opa[nxt]), int'(opb[nxt]), 0);
        end
    endtask

    int   starts         = 0;
    int   last_start_cyc = 0;
    int   last_ack_cyc   = 0;
    logic prev_start     = 1'b0;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (mult_start === 1'b1) begin
                starts++;
                last_start_cyc = cyc;
                chk("start_one_cycle", 32'(prev_start), 0);
                if (op_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_start: mult_a=%0d mult_b=%0d, no start expected", mult_a, mult_b);
                end else begin
                    op_t o;
                    o = op_q.pop_front();
                    chk("mult_a", 32'(mult_a), o.a);
                    chk("mult_b", 32'(mult_b), o.b);
                end
            end
            if (ack !== '0) begin
                last_ack_cyc = cyc;
                chk("busy_at_ack", 32'(busy), 1);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack: ack=%b, no ack expected", ack);
                end else begin
                    rsp_t r;
                    r = exp_q.pop_front();
                    chk("ack_onehot", 32'(ack), 32'(1) << r.id);
                    chk("result_id",  32'(result_id), r.id);
                    chk("result",     32'(result), r.res);
                    chk("err",        32'(err), r.e);
                end
            end
            prev_start = mult_start;
        end else begin
            prev_start = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_acks(input int n, input bit drop, input int budget);
        int got;
        int t;
        got = 0;
        t   = 0;
        while (got < n && t < budget) begin
            @(negedge clk);
            t++;
            if (ack !== '0) begin
                got++;
                if (drop) req = req & ~ack;
            end
        end
        chk("ack_count", got, n);
    endtask

    task automatic wait_start(input int budget);
        int t;
        bit seen;
        t    = 0;
        seen = 1'b0;
        while (!seen && t < budget) begin
            @(negedge clk);
            t++;
            if (mult_start === 1'b1) seen = 1'b1;
        end
        chk("start_seen", 32'(seen), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        rst_n = 1'b0;
        req   = '1;
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = 8'(i + 1);
            opb[i] = 8'd10;
        end

        // Reset held for 3 cycles with every request high.
        for (int r = 0; r < 3; r++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_ack",        32'(ack), 0);
            chk("rst_err",        32'(err), 0);
            chk("rst_result",     32'(result), 0);
            chk("rst_result_id",  32'(result_id), 0);
            chk("rst_busy",       32'(busy), 0);
            chk("rst_mult_a",     32'(mult_a), 0);
            chk("rst_mult_b",     32'(mult_b), 0);
            chk("rst_mult_start", 32'(mult_start), 0);
        end

        // Fairness with all requests held: 0,1,2,3,0.
        last_served = NREQ - 1;
        predict(4'b1111);
        predict(4'b0001);
        rst_n = 1'b1;
        wait_acks(5, 1'b0, 200);
        req = '0;
        repeat (3) @(negedge clk);

        // Single request 3*4.
        opa[0] = 8'd3;
        opb[0] = 8'd4;
        s0 = starts;
        predict(4'b0001);
        req = 4'b0001;
        wait_acks(1, 1'b1, 50);
        repeat (3) @(negedge clk);
        chk("single_start_count", starts - s0, 1);
        chk("result_hold",        32'(result), 12);
        chk("result_id_hold",     32'(result_id), 0);
        chk("idle_busy",          32'(busy), 0);
        chk("idle_ack",           32'(ack), 0);

        // Multiplier never answers: timeout on requester 2.
        hang   = 1'b1;
        opa[2] = 8'd5;
        opb[2] = 8'd5;
        push_txn(2, 5, 5, 1);
        req = 4'b0100;
        wait_acks(1, 1'b1, TIMEOUT + 20);
        @(posedge clk);
        chk("timeout_latency", last_ack_cyc - (last_start_cyc + 1), TIMEOUT);
        @(negedge clk);
        chk("err_hold", 32'(err), 1);

        // Next request after the timeout is served normally.
        hang   = 1'b0;
        lat    = 3;
        opa[3] = 8'd7;
        opb[3] = 8'd9;
        predict(4'b1000);
        req = 4'b1000;
        wait_acks(1, 1'b1, 50);
        repeat (2) @(negedge clk);

        // Stale done (with old product 63) still high through GUARD.
        stale_n = 1;
        lat     = 1;
        opa[1]  = 8'd255;
        opb[1]  = 8'd255;
        predict(4'b0010);
        req = 4'b0010;
        wait_acks(1, 1'b1, 50);
        repeat (2) @(negedge clk);
        stale_n = 0;

        // Reset during WAIT for requester 1 (rr_ptr is 1 at this point).
        hang   = 1'b1;
        opa[1] = 8'd11;
        opb[1] = 8'd13;
        op_q.push_back('{a: 11, b: 13});
        req = 4'b0010;
        wait_start(20);
        repeat (3) @(negedge clk);
        chk("busy_in_wait", 32'(busy), 1);
        rst_n  = 1'b0;
        opa[2] = 8'd21;
        opb[2] = 8'd3;
        req    = 4'b0110;
        @(negedge clk);
        chk("midrst_ack",    32'(ack), 0);
        chk("midrst_busy",   32'(busy), 0);
        chk("midrst_result", 32'(result), 0);
        chk("midrst_err",    32'(err), 0);
        hang = 1'b0;
        lat  = 2;
        last_served = NREQ - 1;
        predict(4'b0110);
        rst_n = 1'b1;
        wait_acks(2, 1'b1, 100);
        repeat (2) @(negedge clk);

        // Randomized batches of simultaneous requests.
        for (int b = 0; b < 25; b++) begin
            logic [NREQ-1:0] mask;
            mask    = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            lat     = $urandom_range(1, 6);
            stale_n = $urandom_range(0, 1);
            for (int i = 0; i < NREQ; i++) begin
                case ($urandom_range(0, 5))
                    0:       begin opa[i] = 8'd0;   opb[i] = 8'($urandom); end
                    1:       begin opa[i] = 8'd255; opb[i] = 8'd255;       end
                    default: begin opa[i] = 8'($urandom); opb[i] = 8'($urandom); end
                endcase
            end
            predict(mask);
            req = mask;
            wait_acks($countones(mask), 1'b1, 20 * NREQ);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("rsp_queue_empty", exp_q.size(), 0);
        chk("op_queue_empty",  op_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Round-robin controller that shares one 8x8 sequential multiplier (`mult`: operands a/b, start, clk, 16-bit r, done) among NREQ requesters.
- Per transaction it does four things in order:
  - accepts one pending request;
  - drives the operands and a start pulse into the multiplier;
  - waits for done, with a timeout;
  - returns the 16-bit product tagged with the requester index.
- Sits between client logic and the single `mult` instance; no other block drives `mult` inputs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester index; must equal ceil(log2(NREQ)).
- TIMEOUT, 64, max cycles to wait for mult_done after start before aborting.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  NREQ  per-requester request level.
- a_in  input  8*NREQ  packed operand a; slice i = a_in[8*i+7:8*i].
- b_in  input  8*NREQ  packed operand b, same packing.
- ack  output  NREQ  one-hot, one-cycle completion pulse to the served requester.
- err  output  1  valid with ack; 1 = timeout, result forced 0.
- result  output  16  product, valid in the ack cycle.
- result_id  output  IDW  index of the served requester, valid in the ack cycle.
- busy  output  1  high in every state except IDLE.
- mult_a  output  8  operand a to the multiplier.
- mult_b  output  8  operand b to the multiplier.
- mult_start  output  1  one-cycle start pulse to the multiplier.
- mult_r  input  16  multiplier result.
- mult_done  input  1  multiplier done level.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE;
  - ack=0, err=0, result=0, result_id=0, busy=0, mult_a=0, mult_b=0, mult_start=0;
  - rr_ptr=NREQ-1, so requester 0 has top priority first;
  - timeout counter=0.
  - Reset mid-operation aborts the transaction silently: no ack, and the multiplier's result is discarded.
- IDLE:
  - If any req bit is high, select the first set bit searching upward from rr_ptr+1, modulo NREQ.
  - Register the selected operands into mult_a/mult_b and store grant_id.
  - Next state is ISSUE. With no req, stay in IDLE.
- ISSUE:
  - mult_start=1 for exactly this cycle; mult_a/mult_b stay stable from now until leaving WAIT.
  - Clear the counter. Next state is GUARD.
- GUARD: one cycle in which mult_done is ignored, so a stale done from the previous operation is never taken. Next state is WAIT.
- WAIT:
  - Counter increments each cycle.
  - If mult_done=1:
    - latch result=mult_r, err=0;
    - go to RESP.
  - Else if counter reaches TIMEOUT-1:
    - result=0, err=1;
    - go to RESP.
  - If done and timeout occur in the same cycle, done wins (err=0).
- RESP:
  - ack[grant_id]=1 for one cycle; result_id=grant_id; rr_ptr=grant_id.
  - Next state is IDLE.
  - result, result_id and err hold their values until the next RESP.
  - ack and mult_start are zero in all other states.
- Requester contract:
  - hold req and its operands stable until its ack;
  - drop req in the cycle after ack;
  - if req is still high in the IDLE cycle after RESP, it counts as a new request.
- Arbitration latency:
  - a request sampled in IDLE produces mult_start 1 cycle later;
  - minimum req-to-ack time is 4 cycles plus the multiplier latency.
- Fairness: after requester i is served it has the lowest priority, so with all req high the service order is 0,1,2,3,0,...
- A requester that drops req while not granted is simply not served; dropping req after grant is ignored and the transaction completes.
- Product is unsigned: 16-bit result = a*b with no truncation; 255*255 = 65025.

Test Plan:
- Reset with rst_n=0 for 3 cycles while req=4'b1111 -> all outputs 0 and busy=0 throughout; the first grant after release goes to requester 0.
- req[0] only, a=3, b=4 -> exactly one mult_start pulse with mult_a=3, mult_b=4; then ack=4'b0001, result=12, result_id=0, err=0.
- req=4'b1111 held, operands i+1 times 10 for requester i -> acks in order 0,1,2,3,0 with results 10,20,30,40,10.
- Multiplier model holds mult_done=0 forever, req[2] with a=5, b=5 -> ack[2] exactly TIMEOUT cycles after GUARD, err=1, result=0; the next request is served normally.
- Multiplier model holds stale mult_done=1 from the previous operation through GUARD -> done is ignored in GUARD; the result captured is the new product (255*255=65025).
- rst_n pulsed low during WAIT for requester 1 -> no ack; returns to IDLE with rr_ptr=NREQ-1; requester 1 is then re-served with the correct result.
